// File: rtl/proj_raster_sequencer.sv
// Raster-order coordinate sequencer for the barrel-projection math core, with credit-limited
// request issue and frame control. Optional inter-line blanking is enabled by SEQ_HBLANK_EN.
module proj_raster_sequencer #(
  parameter int unsigned WIDTH           = 1080,
  parameter int unsigned HEIGHT          = 960,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned HBLANK          = 4,
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          continuous,
  input  logic          abort,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [XW-1:0] req_x,
  output logic [YW-1:0] req_y,
  output logic          req_sof,
  output logic          req_eol,
  input  logic          rsp_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          aborted,
  output logic [15:0]   frame_count,
  output logic [OW-1:0] outstanding,
  output logic          underflow_err
);

`ifdef SEQ_HBLANK_EN
  localparam int unsigned HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHblank} state_t;
  logic [HW-1:0] hb_q, hb_d;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;
`endif

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          abort_q, abort_d;
  logic [OW-1:0] out_q, out_d;
  logic [15:0]   cnt_q;
  logic          underflow_q;
  logic          xfer, last_px, credit;

  assign xfer          = req_valid & req_ready;
  assign last_px       = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
  assign credit        = out_q < OW'(MAX_OUTSTANDING);
  assign req_x         = x_q;
  assign req_y         = y_q;
  assign req_sof       = (x_q == '0) && (y_q == '0);
  assign req_eol       = (x_q == XW'(WIDTH - 1));
  assign busy          = (state_q != StIdle);
  assign frame_count   = cnt_q;
  assign outstanding   = out_q;
  assign underflow_err = underflow_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    abort_d    = abort_q;
    req_valid  = 1'b0;
    frame_done = 1'b0;
    aborted    = 1'b0;
`ifdef SEQ_HBLANK_EN
    hb_d       = hb_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          x_d     = '0;
          y_d     = '0;
          abort_d = 1'b0;
        end
      end
      StRun: begin
        req_valid = credit;
        if (xfer) begin
          if (req_eol) begin
            x_d = '0;
            y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        // abort wins over the last-pixel exit, but a coincident transfer still counts
        if (abort) begin
          state_d = StDrain;
          abort_d = 1'b1;
        end else if (xfer && last_px) begin
          state_d = StDrain;
`ifdef SEQ_HBLANK_EN
        end else if (xfer && req_eol) begin
          state_d = StHblank;
          hb_d    = HW'(HBLANK - 1);
`endif
        end
      end
`ifdef SEQ_HBLANK_EN
      StHblank: begin
        if (abort) begin
          state_d = StDrain;
          abort_d = 1'b1;
        end else if (hb_q == '0) begin
          state_d = StRun;
        end else begin
          hb_d = hb_q - HW'(1);
        end
      end
`endif
      StDrain: begin
        if (out_q == '0) begin
          x_d     = '0;
          y_d     = '0;
          abort_d = 1'b0;
          if (abort_q) begin
            aborted = 1'b1;
            state_d = StIdle;
          end else begin
            frame_done = 1'b1;
            state_d    = continuous ? StRun : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Simultaneous transfer and response leave the count unchanged.
  always_comb begin
    out_d = out_q;
    unique case ({xfer, rsp_valid})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = (out_q == '0) ? '0 : out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      abort_q     <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
`ifdef SEQ_HBLANK_EN
      hb_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      abort_q <= abort_d;
      out_q   <= out_d;
      if (frame_done) cnt_q <= cnt_q + 16'd1;
      if (rsp_valid && (out_q == '0)) underflow_q <= 1'b1;
`ifdef SEQ_HBLANK_EN
      hb_q    <= hb_d;
`endif
    end
  end

endmodule

// File: tb/tb_proj_raster_sequencer.sv
// Directed self-checking bench for proj_raster_sequencer using a 4x3 raster and two credits.
module tb_proj_raster_sequencer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int M = 2;

  logic       clk = 1'b0;
  logic       reset, start, continuous, abort, req_ready, rsp_valid;
  logic       req_valid, req_sof, req_eol, busy, frame_done, aborted, underflow_err;
  logic [1:0] req_x, req_y, outstanding;
  logic [15:0] frame_count;

  proj_raster_sequencer #(
    .WIDTH(W), .HEIGHT(H), .MAX_OUTSTANDING(M), .HBLANK(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_sof(req_sof), .req_eol(req_eol), .rsp_valid(rsp_valid), .busy(busy),
    .frame_done(frame_done), .aborted(aborted), .frame_count(frame_count),
    .outstanding(outstanding), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_xfer = 0;
  int         done_cnt = 0;
  int         abort_cnt = 0;
  int         exp_x = 0;
  int         exp_y = 0;
  int         base, d0, a0, i;
  bit         auto_rsp = 1'b0;
  bit         stall_prev = 1'b0;
  logic [2:0] pipe = '0;
  logic [1:0] sx, sy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples outputs just before the edge, advances one clock, then drives the responder.
  task automatic step();
    logic xfer;
    xfer = req_valid && req_ready;
    if (stall_prev && req_valid) begin
      check("stall_hold_x", 32'(req_x), 32'(sx));
      check("stall_hold_y", 32'(req_y), 32'(sy));
    end
    stall_prev = req_valid && !req_ready;
    sx = req_x;
    sy = req_y;
    if (xfer) begin
      check("req_x", 32'(req_x), exp_x);
      check("req_y", 32'(req_y), exp_y);
      check("req_sof", 32'(req_sof), 32'(exp_x == 0 && exp_y == 0));
      check("req_eol", 32'(req_eol), 32'(exp_x == W - 1));
      n_xfer++;
      if (exp_x == W - 1) begin
        exp_x = 0;
        exp_y = (exp_y == H - 1) ? 0 : exp_y + 1;
      end else begin
        exp_x++;
      end
    end
    if (frame_done === 1'b1) done_cnt++;
    if (aborted === 1'b1) abort_cnt++;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      rsp_valid = pipe[2];
      pipe = {pipe[1:0], xfer};
    end
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  task automatic check_reset_values();
    check("rst_req_valid", 32'(req_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_underflow", 32'(underflow_err), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_aborted", 32'(aborted), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0;
    step();
    step();
    check_reset_values();

    // Single frame, responses trail each transfer by a few cycles.
    reset = 1'b0; req_ready = 1'b1; auto_rsp = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("start_latency_valid", 32'(req_valid), 1);
    check("start_busy", 32'(busy), 1);
    check("start_sof", 32'(req_sof), 1);
    run_until_idle(200, "frame1_idle");
    check("frame1_xfers", n_xfer, 12);
    check("frame1_done_pulses", done_cnt, 1);
    check("frame1_count", 32'(frame_count), 1);
    check("frame1_outstanding", 32'(outstanding), 0);

    // Credit limit with responses withheld.
    auto_rsp = 1'b0; rsp_valid = 1'b0; pipe = '0; base = n_xfer; exp_x = 0; exp_y = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    check("credit_xfers", n_xfer - base, 2);
    check("credit_outstanding", 32'(outstanding), 2);
    check("credit_valid_low", 32'(req_valid), 0);
    rsp_valid = 1'b1; step(); rsp_valid = 1'b0;
    repeat (5) step();
    check("credit_one_more", n_xfer - base, 3);
    check("credit_outstanding2", 32'(outstanding), 2);
    pipe = 3'b110; auto_rsp = 1'b1;
    run_until_idle(300, "frame2_idle");
    check("frame2_xfers", n_xfer - base, 12);
    check("frame2_done_pulses", done_cnt, 2);
    check("frame2_count", 32'(frame_count), 2);

    // Random back-pressure.
    base = n_xfer; exp_x = 0; exp_y = 0;
    start = 1'b1; step(); start = 1'b0;
    i = 0;
    while (busy !== 1'b0 && i < 400) begin
      req_ready = 1'($urandom_range(0, 1));
      step();
      i++;
    end
    req_ready = 1'b1;
    check("stall_idle", 32'(busy), 0);
    check("stall_xfers", n_xfer - base, 12);
    check("stall_count", 32'(frame_count), 3);
    check("stall_done_pulses", done_cnt, 3);

    // Continuous mode for three frames.
    base = n_xfer; d0 = done_cnt; exp_x = 0; exp_y = 0;
    continuous = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    i = 0;
    while (done_cnt < d0 + 2 && i < 500) begin
      step();
      i++;
    end
    continuous = 1'b0;
    run_until_idle(500, "cont_idle");
    check("cont_done_pulses", done_cnt - d0, 3);
    check("cont_xfers", n_xfer - base, 36);
    check("cont_count", 32'(frame_count), 6);

    // Abort coinciding with the (2,1) transfer, two requests in flight.
    base = n_xfer; a0 = abort_cnt; d0 = done_cnt; exp_x = 0; exp_y = 0;
    auto_rsp = 1'b0; rsp_valid = 1'b0; pipe = '0;
    start = 1'b1; step(); start = 1'b0;
    i = 0;
    while (outstanding !== 2'd2 && i < 20) begin
      step();
      i++;
    end
    check("abort_prefill", 32'(outstanding), 2);
    i = 0;
    while (!(req_valid === 1'b1 && req_x == 2'd2 && req_y == 2'd1) && i < 50) begin
      rsp_valid = 1'b1;
      step();
      i++;
    end
    rsp_valid = 1'b0;
    check("abort_at_x", 32'(req_x), 2);
    check("abort_at_y", 32'(req_y), 1);
    check("abort_at_outstanding", 32'(outstanding), 1);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_xfers", n_xfer - base, 7);
    check("abort_outstanding", 32'(outstanding), 2);
    check("abort_valid_low", 32'(req_valid), 0);
    check("abort_busy", 32'(busy), 1);
    repeat (4) step();
    check("abort_no_more_xfers", n_xfer - base, 7);
    check("abort_no_early_pulse", abort_cnt, a0);
    rsp_valid = 1'b1; step(); step(); rsp_valid = 1'b0;
    check("abort_pulse", 32'(aborted), 1);
    check("abort_no_done", 32'(frame_done), 0);
    check("abort_drained", 32'(outstanding), 0);
    step();
    check("abort_idle", 32'(busy), 0);
    check("abort_pulse_gone", 32'(aborted), 0);
    check("abort_count_kept", 32'(frame_count), 6);
    check("abort_pulse_count", abort_cnt - a0, 1);
    check("abort_done_count", done_cnt - d0, 0);

    // Response with nothing in flight.
    check("uf_clear_before", 32'(underflow_err), 0);
    rsp_valid = 1'b1; step(); rsp_valid = 1'b0;
    check("uf_set", 32'(underflow_err), 1);
    check("uf_outstanding", 32'(outstanding), 0);
    repeat (3) step();
    check("uf_sticky", 32'(underflow_err), 1);
    check("uf_idle", 32'(busy), 0);

    // Reset in the middle of a frame.
    exp_x = 0; exp_y = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("mid_outstanding", 32'(outstanding), 2);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1; step();
    check_reset_values();
    reset = 1'b0; d0 = done_cnt; a0 = abort_cnt;
    repeat (3) step();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_valid", 32'(req_valid), 0);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_no_abort", abort_cnt - a0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
